// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port byte-addressed data memory.
// Each access takes three cycles: grant, memory access, response.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_we,
  input  logic [1:0]            m0_size,
  input  logic                  m0_unsigned,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_we,
  input  logic [1:0]            m1_size,
  input  logic                  m1_unsigned,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_SIZE * 4 - 3);

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_last;
  logic                    r_owner;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_we;
  logic [1:0]              r_size;
  logic                    r_uns;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;

  logic                    w_any;
  logic                    w_sel;
  logic                    w_grant;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [1:0]              w_size;
  logic                    w_err;
  logic                    w_access;
  logic                    w_resp;
  logic [DATA_WIDTH-1:0]   w_ld;
  logic [DATA_WIDTH-1:0]   w_cap;

  // On a tie the port that was not granted last wins; r_last holds the last winner.
  assign w_any   = m0_req | m1_req;
  assign w_sel   = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_grant = (r_state == S_IDLE) & w_any & ~rst;
  assign w_addr  = w_sel ? m1_addr : m0_addr;
  assign w_size  = w_sel ? m1_size : m0_size;

  assign w_err = (w_size == 2'b11)
               | ((w_size == 2'b01) & w_addr[0])
               | ((w_size == 2'b10) & (|w_addr[1:0]))
               | (w_addr >= LIMIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    case (r_size)
      2'b00:   w_ld = {{(DATA_WIDTH-8){~r_uns & mem_rdata[7]}}, mem_rdata[7:0]};
      2'b01:   w_ld = {{(DATA_WIDTH-16){~r_uns & mem_rdata[15]}}, mem_rdata[15:0]};
      default: w_ld = mem_rdata;
    endcase
    w_cap = (r_we | r_err) ? '0 : w_ld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_last  <= w_sel;
        r_owner <= w_sel;
        r_addr  <= w_addr;
        r_we    <= w_sel ? m1_we : m0_we;
        r_size  <= w_size;
        r_uns   <= w_sel ? m1_unsigned : m0_unsigned;
        r_wdata <= w_sel ? m1_wdata : m0_wdata;
        r_err   <= w_err;
      end
      if (r_state == S_ACCESS) r_rdata <= w_cap;
    end
  end

  assign w_access = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);

  assign mem_addr  = w_access ? r_addr : '0;
  assign mem_wdata = w_access ? r_wdata : '0;
  assign mem_we    = w_access & r_we & ~r_err;

  always_comb begin
    mem_be = '0;
    if (w_access) begin
      case (r_size)
        2'b00:   mem_be = 4'b0001;
        2'b01:   mem_be = 4'b0011;
        2'b10:   mem_be = 4'b1111;
        default: mem_be = 4'b0000;
      endcase
    end
  end

  assign m0_gnt    = w_grant & ~w_sel;
  assign m1_gnt    = w_grant & w_sel;
  assign m0_rvalid = w_resp & ~r_owner;
  assign m1_rvalid = w_resp & r_owner;
  assign m0_rdata  = m0_rvalid ? r_rdata : '0;
  assign m1_rdata  = m1_rvalid ? r_rdata : '0;
  assign m0_err    = m0_rvalid & r_err;
  assign m1_err    = m1_rvalid & r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed and random accesses against a byte-array reference model,
// with a behavioural byte-addressed memory attached to the mem_* port.
module tb_dmem_arbiter;
  localparam int MS = 1024;
  localparam int NB = MS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_unsigned, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_we, m1_unsigned, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;

  logic [7:0]  mem  [NB] = '{default: 8'h00};
  logic [7:0]  refm [NB] = '{default: 8'h00};

  int ntests = 0;
  int nfail  = 0;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_size(m0_size),
    .m0_unsigned(m0_unsigned), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_size(m1_size),
    .m1_unsigned(m1_unsigned), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read of addr..addr+3, byte-enabled write on the clock edge.
  always @(posedge clk) begin
    if (mem_we && mem_addr <= 32'(NB - 4))
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 32'(NB - 4))
      for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = mem[int'(mem_addr) + i];
  end

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0)
           || (a > 32'(NB - 4));
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] s,
                                           input logic u);
    int     n = nbytes(s);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(refm[int'(a) + i]) << (8 * i));
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
    for (int i = 0; i < nbytes(s); i++) refm[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic rq, input logic [31:0] a, input logic we,
                       input logic [1:0] s, input logic u, input logic [31:0] wd);
    if (p == 0) begin
      m0_req = rq; m0_addr = a; m0_we = we; m0_size = s; m0_unsigned = u; m0_wdata = wd;
    end else begin
      m1_req = rq; m1_addr = a; m1_we = we; m1_size = s; m1_unsigned = u; m1_wdata = wd;
    end
  endtask

  function automatic logic get_gnt(input int p);
    return (p == 0) ? m0_gnt : m1_gnt;
  endfunction

  function automatic logic [33:0] get_resp(input int p);
    return (p == 0) ? {m0_rvalid, m0_err, m0_rdata} : {m1_rvalid, m1_err, m1_rdata};
  endfunction

  // Called on the grant cycle (just after a negedge sample); checks ACCESS and RESP cycles.
  task automatic finish(input int p, input logic [31:0] a, input logic we, input logic [1:0] s,
                        input logic u, input logic [31:0] wd);
    logic        e   = exp_err(a, s);
    logic [31:0] erd = (we || e) ? 32'h0 : exp_load(a, s, u);
    logic [33:0] r;
    @(negedge clk);
    drive(p, 1'b0, a, we, s, u, wd);
    #1;
    chk("access_mem_we", 32'(mem_we), 32'(we && !e));
    if (!e) begin
      chk("access_mem_be", 32'(mem_be), 32'((1 << nbytes(s)) - 1));
      chk("access_mem_addr", mem_addr, a);
    end
    chk("access_no_rvalid", 32'(m0_rvalid | m1_rvalid), 32'h0);
    if (we && !e) model_store(a, s, wd);
    @(negedge clk);
    #1;
    r = get_resp(p);
    chk("resp_rvalid", 32'(r[33]), 32'h1);
    chk("resp_err", 32'(r[32]), 32'(e));
    chk("resp_rdata", r[31:0], erd);
    chk("resp_other_quiet", 32'(get_resp(1 - p)), 32'h0);
    chk("resp_mem_we", 32'(mem_we), 32'h0);
  endtask

  task automatic txn(input int p, input logic [31:0] a, input logic we, input logic [1:0] s,
                     input logic u, input logic [31:0] wd);
    int k = 0;
    @(negedge clk);
    drive(p, 1'b1, a, we, s, u, wd);
    #1;
    while (get_gnt(p) !== 1'b1 && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("gnt", 32'(get_gnt(p)), 32'h1);
    chk("gnt_other", 32'(get_gnt(1 - p)), 32'h0);
    finish(p, a, we, s, u, wd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    int          p;
    drive(0, 1'b0, '0, 1'b0, 2'd0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, 2'd0, 1'b0, '0);
    rst = 1'b1;
    #12;
    chk("reset_outputs", {m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_we,
                          mem_be, 21'h0}, 32'h0);
    chk("reset_mem_addr", mem_addr | mem_wdata | m0_rdata | m1_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    txn(0, 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
    txn(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
    chk("word_readback_model", exp_load(32'h10, 2'd2, 1'b0), 32'hDEADBEEF);
    txn(0, 32'h21, 1'b1, 2'd0, 1'b0, 32'h80);
    txn(0, 32'h21, 1'b0, 2'd0, 1'b0, 32'h0);
    txn(0, 32'h21, 1'b0, 2'd0, 1'b1, 32'h0);
    txn(0, 32'h22, 1'b1, 2'd1, 1'b0, 32'h8001);
    txn(0, 32'h22, 1'b0, 2'd1, 1'b0, 32'h0);
    txn(0, 32'h22, 1'b0, 2'd1, 1'b1, 32'h0);

    // Error responses.
    txn(0, 32'h102, 1'b1, 2'd2, 1'b0, 32'h11223344);
    txn(1, 32'h5, 1'b0, 2'd1, 1'b0, 32'h0);
    txn(0, 32'h8, 1'b0, 2'd3, 1'b0, 32'h0);
    txn(1, 32'(NB - 3), 1'b0, 2'd2, 1'b0, 32'h0);
    txn(0, 32'(NB - 4), 1'b0, 2'd2, 1'b0, 32'h0);

    // Both ports held: alternating grants every three cycles, port 0 first after reset.
    do_reset();
    @(negedge clk);
    drive(0, 1'b1, 32'h0, 1'b0, 2'd2, 1'b0, '0);
    drive(1, 1'b1, 32'h4, 1'b0, 2'd2, 1'b0, '0);
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("rr_gnt0", 32'(m0_gnt), 32'(c % 6 == 0));
      chk("rr_gnt1", 32'(m1_gnt), 32'(c % 6 == 3));
      if (c % 3 == 2) begin
        p = ((c - 2) % 6 == 0) ? 0 : 1;
        chk("rr_rvalid_owner", 32'(get_resp(p)), {2'b10, exp_load(32'(4 * p), 2'd2, 1'b0)});
        chk("rr_rvalid_other", 32'(get_resp(1 - p)), 32'h0);
      end
      @(negedge clk);
    end
    drive(0, 1'b0, '0, 1'b0, 2'd0, 1'b0, '0);
    drive(1, 1'b0, '0, 1'b0, 2'd0, 1'b0, '0);

    // Reset during a port 1 store's ACCESS cycle.
    @(negedge clk);
    drive(1, 1'b1, 32'h40, 1'b1, 2'd2, 1'b0, 32'h12345678);
    #1;
    chk("rst_store_gnt", 32'(m1_gnt), 32'h1);
    @(negedge clk);
    drive(1, 1'b0, 32'h40, 1'b1, 2'd2, 1'b0, 32'h12345678);
    #1;
    chk("rst_store_access_we", 32'(mem_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mem_we_drop", 32'(mem_we), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("rst_no_rvalid", 32'(m0_rvalid | m1_rvalid), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 32'h40, 1'b0, 2'd2, 1'b0, '0);
    drive(1, 1'b1, 32'h44, 1'b0, 2'd2, 1'b0, '0);
    #1;
    chk("post_rst_tie_gnt0", 32'(m0_gnt), 32'h1);
    chk("post_rst_tie_gnt1", 32'(m1_gnt), 32'h0);
    drive(1, 1'b0, 32'h44, 1'b0, 2'd2, 1'b0, '0);
    finish(0, 32'h40, 1'b0, 2'd2, 1'b0, '0);

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      p = int'($urandom_range(0, 1));
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) a = a & ~32'(nbytes(s) - 1);
      if ($urandom_range(0, 15) == 0) a = 32'(NB - 8) + 32'($urandom_range(0, 11));
      txn(p, a, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
